// File: rtl/inst_loader.sv
// Instruction loader: streams a length-prefixed program into instruction memory,
// verifies a trailing 16-bit additive checksum, then releases the CPU from reset.
module inst_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] load_len,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned LEN_W   = 13;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAX_LEN = 4096;
    // Idle counter only needs to reach TIMEOUT_CYCLES-1 before the expiring cycle.
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    len;
    logic [LEN_W-1:0]    wcnt;
    logic [DATA_W-1:0]   acc;
    logic [TO_W-1:0]     tcnt;

    logic hs;
    logic len_ok;

    // Input handshake and start-length legality.
    assign hs     = in_valid & in_ready;
    assign len_ok = (load_len != LEN_W'(0)) && (load_len <= LEN_W'(MAX_LEN));

    // Loader FSM: state, datapath counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            wcnt       <= '0;
            acc        <= '0;
            tcnt       <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_ERROR: begin
                    if (start) begin
                        if (len_ok) begin
                            state     <= S_LOAD;
                            len       <= load_len;
                            wcnt      <= '0;
                            acc       <= '0;
                            tcnt      <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            cpu_reset <= 1'b1;
                        end else begin
                            state     <= S_ERROR;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b0;
                            err       <= 1'b1;
                            cpu_reset <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (hs) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wcnt[ADDR_W-1:0];
                        imem_wdata <= in_data;
                        wcnt       <= wcnt + LEN_W'(1);
                        acc        <= acc + in_data;
                        tcnt       <= '0;
                        if ((wcnt + LEN_W'(1)) == len) begin
                            state <= S_CHECK;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                S_CHECK: begin
                    if (hs) begin
                        tcnt     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == acc) begin
                            state     <= S_RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end else if (tcnt == TO_LAST) begin
                        state    <= S_ERROR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: max consecutive cycles without an input handshake in LOAD/CHECK.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to (re)load a program; sampled in IDLE, RUN and ERROR only.
REQ-005 SHALL have port load_len  input  13  number of instruction words to load; valid range 1..4096; sampled on accepted start.
REQ-006 SHALL have port in_valid  input  1  source has a word on in_data.
REQ-007 SHALL have port in_data  input  16  instruction or checksum word.
REQ-008 SHALL have port in_ready  output  1  loader accepts in_data; handshake = in_valid & in_ready at a rising edge.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per data word.
REQ-010 SHALL have port imem_addr  output  12  instruction-memory write address.
REQ-011 SHALL have port imem_wdata  output  16  instruction-memory write data.
REQ-012 SHALL have port cpu_reset  output  1  held-in-reset signal to the pipeline (ProgramCounter and pipeline registers); 1 = CPU held.
REQ-013 SHALL have ports busy, done, err  output  1 each: loading in progress / program running / load failed.

Function
REQ-014 SHALL implement states IDLE, LOAD, CHECK, RUN, ERROR.
REQ-015 IDLE: start & load_len in 1..4096 -> LOAD (latch length, word counter = 0, checksum accumulator = 0, timeout counter = 0); start with load_len = 0 or > 4096 -> ERROR.
REQ-016 RUN and ERROR: start is treated exactly as in IDLE (reload or error); start in LOAD/CHECK is ignored.
REQ-017 in_ready SHALL be decoded from current state: 1 in LOAD and CHECK, 0 otherwise.
REQ-018 LOAD: each handshake registers imem_we = 1, imem_addr = word counter[11:0], imem_wdata = in_data for exactly the following cycle; counter += 1; accumulator += in_data mod 2^16.
REQ-019 imem_we SHALL be 0 in every cycle not following a LOAD handshake; imem_addr/imem_wdata hold their last values.
REQ-020 LOAD -> CHECK on the handshake that accepts word number load_len (last data word).
REQ-021 CHECK: one handshake accepts the checksum word, no memory write; equal to accumulator -> RUN, else -> ERROR.
REQ-022 Timeout: in LOAD/CHECK, counter increments each cycle without handshake, clears on handshake; reaching TIMEOUT_CYCLES -> ERROR; a handshake in that same cycle takes priority (counts as progress).
REQ-023 cpu_reset = 0 only in RUN; 1 in all other states, including the first cycle after start in RUN.
REQ-024 busy = 1 in LOAD and CHECK; done = 1 in RUN; err = 1 in ERROR; all registered and mutually exclusive.
REQ-025 load_len = 4096 SHALL write addresses 0..4095 with no wrap before CHECK; the counter SHALL be 13 bits wide.

Reset
REQ-026 reset SHALL take priority over all inputs, including an in-flight handshake, whose word is discarded.
REQ-027 After reset: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_reset 1, busy 0, done 0, err 0, all counters and accumulator 0.
REQ-028 reset asserted mid-LOAD SHALL return to IDLE with no further imem_we pulse in the following cycle.

Verification
REQ-029 start, load_len=3; words 0x1111, 0x2222, 0x3333, checksum 0x6666 back-to-back -> writes addr 0/1/2 with those data, then RUN, cpu_reset 0, done 1.
REQ-030 load_len=2; words 0xFFFF, 0x0002, checksum 0x0001 -> RUN (mod-2^16 wrap); checksum 0x0000 -> ERROR, err 1, cpu_reset 1.
REQ-031 load_len=0 or 4097 with start in IDLE -> ERROR next cycle, no imem_we pulse.
REQ-032 TIMEOUT_CYCLES=8, load_len=4; after 2 words hold in_valid 0 -> ERROR exactly 8 cycles after the last handshake.
REQ-033 in_valid toggling every other cycle, load_len=4 -> exactly 4 imem_we pulses, addr 0..3, no duplicates; start asserted during LOAD ignored.
REQ-034 reset asserted in same cycle as 2nd handshake of a 5-word load -> IDLE, outputs per REQ-027; subsequent start reloads from addr 0.
